// File: rtl/reduce_tree_pipe.sv
// Pipelined radix-4 OR/AND/XOR/NOR reduction tree with valid/ready flow control.
// Optional feature: define REDUCE_ACCUM_EN to add in_last/out_acc and a consumed-beat accumulator.
module reduce_tree_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef REDUCE_ACCUM_EN
  input  logic             in_last,
  output logic             out_acc,
`endif
  output logic             out_data,
  output logic [1:0]       out_op,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam int LEVELS = ($clog2(WIDTH) + 1) / 2;

  function automatic int lvl_width(input int lvl);
    int w;
    w = WIDTH;
    for (int i = 0; i < lvl; i++) w = (w + 3) / 4;
    return w;
  endfunction

  // Every level's registered bits live in one flat bus; this gives a level's offset in it.
  function automatic int lvl_off(input int lvl);
    int o;
    o = 0;
    for (int k = 1; k < lvl; k++) o += lvl_width(k);
    return o;
  endfunction

  localparam int TOT = lvl_off(LEVELS + 1);

  function automatic logic gate4(input logic [3:0] grp, input logic [1:0] op);
    logic r;
    case (op)
      OP_AND:  r = &grp;
      OP_XOR:  r = ^grp;
      default: r = |grp;
    endcase
    return r;
  endfunction

  logic                   en;
  logic [TOT-1:0]         data_r;
  logic [TOT-1:0]         data_nxt;
  logic [LEVELS-1:0][1:0] op_r;
  logic [LEVELS-1:0]      valid_r;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_data  = data_r[TOT-1];
  assign out_op    = op_r[LEVELS-1];
  assign out_valid = valid_r[LEVELS-1];

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int IW = lvl_width(l);
    localparam int OW = lvl_width(l + 1);
    localparam int OO = lvl_off(l + 1);
    logic [IW-1:0] src;
    logic [1:0]    src_op;
    if (l == 0) begin : g_first
      assign src    = in_data;
      assign src_op = in_op;
    end else begin : g_next
      assign src    = data_r[lvl_off(l) +: IW];
      assign src_op = op_r[l-1];
    end
    for (genvar g = 0; g < OW; g++) begin : g_grp
      logic [3:0] grp;
      for (genvar k = 0; k < 4; k++) begin : g_bit
        if (4 * g + k < IW) begin : g_in
          assign grp[k] = src[4*g+k];
        end else begin : g_pad
          assign grp[k] = (src_op == OP_AND);
        end
      end
      // NOR travels as OR and is inverted only when leaving the last level.
      if (l == LEVELS - 1) begin : g_final
        assign data_nxt[OO+g] = gate4(grp, src_op) ^ (src_op == OP_NOR);
      end else begin : g_mid
        assign data_nxt[OO+g] = gate4(grp, src_op);
      end
    end
  end

  // Advance every stage together; a stalled output freezes the whole tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {TOT{1'b0}};
      op_r    <= {(2*LEVELS){1'b0}};
      valid_r <= {LEVELS{1'b0}};
    end else if (en) begin
      data_r     <= data_nxt;
      op_r[0]    <= in_op;
      valid_r[0] <= in_valid;
      for (int i = 1; i < LEVELS; i++) begin
        op_r[i]    <= op_r[i-1];
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

`ifdef REDUCE_ACCUM_EN
  logic [LEVELS-1:0] last_r;
  logic              acc_or_r;
  logic              acc_and_r;
  logic              acc_xor_r;
  logic              pre;
  logic              sum_or;
  logic              sum_and;
  logic              sum_xor;

  assign pre     = out_data ^ (out_op == OP_NOR);
  assign sum_or  = acc_or_r | pre;
  assign sum_and = acc_and_r & pre;
  assign sum_xor = acc_xor_r ^ pre;

  // Carry the frame-end flag alongside its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= {LEVELS{1'b0}};
    end else if (en) begin
      last_r[0] <= in_last;
      for (int i = 1; i < LEVELS; i++) last_r[i] <= last_r[i-1];
    end
  end

  // All three running reductions are kept so each beat can apply its own op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_or_r  <= 1'b0;
      acc_and_r <= 1'b1;
      acc_xor_r <= 1'b0;
    end else if (out_valid && out_ready) begin
      if (last_r[LEVELS-1]) begin
        acc_or_r  <= 1'b0;
        acc_and_r <= 1'b1;
        acc_xor_r <= 1'b0;
      end else begin
        acc_or_r  <= sum_or;
        acc_and_r <= sum_and;
        acc_xor_r <= sum_xor;
      end
    end
  end

  // Select the accumulated result for the op of the beat now at the output.
  always_comb begin
    case (out_op)
      OP_AND:  out_acc = sum_and;
      OP_XOR:  out_acc = sum_xor;
      OP_NOR:  out_acc = ~sum_or;
      default: out_acc = sum_or;
    endcase
  end
`endif

endmodule
